// File: rtl/spi_burst_pkg.sv
// Shared types and constants for the SPI burst sequencer and its FIFOs.
package spi_burst_pkg;

    localparam int BYTE_W = 8;

    localparam logic [BYTE_W-1:0] FILL_DEFAULT = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_CAPTURE,
        ST_DONE
    } state_e;

endpackage

// File: rtl/spi_burst_ctrl_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; a pop in the same cycle
// frees a slot for a push even when the FIFO is full.
module sync_fifo
    import spi_burst_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = BYTE_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   rd,
    output logic [WIDTH-1:0]       rdata,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full;
    logic             rd_ok;
    logic             wr_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign count = count_q;
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

    assign rd_ok = rd && !empty;
    assign wr_ok = wr && (!full || rd_ok);

    always_comb begin
        wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; the count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/spi_burst_ctrl.sv
// Runs multi-byte SPI bursts: feeds TX FIFO bytes to the SPI master one at a
// time through its start/busy handshake and collects replies in an RX FIFO.
module spi_burst_ctrl
    import spi_burst_pkg::*;
#(
    parameter int                DEPTH = 8,
    parameter int                LEN_W = 8,
    parameter logic [BYTE_W-1:0] FILL  = FILL_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tx_wr,
    input  logic [BYTE_W-1:0]      tx_wdata,
    output logic                   tx_full,
    output logic [$clog2(DEPTH):0] tx_count,
    input  logic                   rx_rd,
    output logic [BYTE_W-1:0]      rx_rdata,
    output logic                   rx_empty,
    input  logic                   go,
    input  logic [LEN_W-1:0]       len,
    input  logic                   clr_ovf,
    output logic                   active,
    output logic                   done,
    output logic                   rx_ovf,
    output logic [BYTE_W-1:0]      spi_tx_data,
    output logic                   spi_start,
    input  logic                   spi_busy,
    input  logic [BYTE_W-1:0]      spi_rx_data
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [BYTE_W-1:0] spi_tx_data_q, spi_tx_data_d;
    logic              spi_start_q, spi_start_d;
    logic              rx_ovf_q, rx_ovf_d;

    logic              tx_rd;
    logic              tx_empty;
    logic [BYTE_W-1:0] tx_head;
    logic              rx_push;
    logic              rx_full;
    logic              rx_drop;
    logic [CW-1:0]     rx_count;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BYTE_W)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (tx_wr),
        .wdata (tx_wdata),
        .rd    (tx_rd),
        .rdata (tx_head),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BYTE_W)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (rx_push),
        .wdata (spi_rx_data),
        .rd    (rx_rd),
        .rdata (rx_rdata),
        .empty (rx_empty),
        .count (rx_count)
    );

    assign tx_full = (tx_count == FULL_CNT);
    assign rx_full = (rx_count == FULL_CNT);

    // A same-cycle pop frees the slot first, so only an unread full FIFO drops.
    assign rx_drop = rx_push && rx_full && !rx_rd;

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case infers a latch.
        state_d       = state_q;
        rem_d         = rem_q;
        spi_tx_data_d = spi_tx_data_q;
        tx_rd         = 1'b0;
        rx_push       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (go) begin
                    if (len != '0) begin
                        rem_d   = len;
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_LOAD: begin
                tx_rd         = !tx_empty;
                spi_tx_data_d = tx_empty ? FILL : tx_head;
                state_d       = ST_START;
            end
            ST_START: begin
                if (spi_busy) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!spi_busy) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                rx_push = 1'b1;
                rem_d   = rem_q - 1'b1;
                state_d = (rem_d != '0) ? ST_LOAD : ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Registered so the start request drops on the same edge that sees busy.
        spi_start_d = (state_d == ST_START);
        rx_ovf_d    = rx_drop ? 1'b1 : (clr_ovf ? 1'b0 : rx_ovf_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            rem_q         <= '0;
            spi_tx_data_q <= '0;
            spi_start_q   <= 1'b0;
            rx_ovf_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            rem_q         <= rem_d;
            spi_tx_data_q <= spi_tx_data_d;
            spi_start_q   <= spi_start_d;
            rx_ovf_q      <= rx_ovf_d;
        end
    end

    assign active      = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign rx_ovf      = rx_ovf_q;
    assign spi_tx_data = spi_tx_data_q;
    assign spi_start   = spi_start_q;

endmodule
